// File: rtl/com_pkg.sv
// Shared types and constants for the MCU command intake path.
// Defines the queued word layout, opcode values and the head-nibble decoder.
package com_pkg;

  typedef struct packed {
    logic       cmd;
    logic [8:0] data;
  } com_word_t;

  localparam logic [3:0] FLIP      = 4'd0;
  localparam logic [3:0] POLYLINE  = 4'd1;
  localparam logic [3:0] TRI_COLOR = 4'd2;
  localparam logic [3:0] TRIANGLE  = 4'd3;
  localparam logic [3:0] COLOR     = 4'd4;
  localparam logic [3:0] DOT       = 4'd5;

  localparam int DEC_W = 16;

  // One-hot decode of a nibble, forced to zero when not enabled.
  function automatic logic [DEC_W-1:0] decodeOneHot(input logic [3:0] nib, input logic en);
    logic [DEC_W-1:0] res;
    res = {DEC_W{1'b0}};
    for (int k = 0; k < DEC_W; k++) begin
      if (en && (nib == 4'(k))) begin
        res[k] = 1'b1;
      end else begin
        res[k] = 1'b0;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/com_fifo_debounce.sv
// Write-strobe conditioner: 2-flop synchronizer, stability counter and a
// single-cycle pulse on each debounced 0->1 transition.
module debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iGo,
  output logic oRise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          syncA;
  logic          syncB;
  logic          stateR;
  logic [CW-1:0] cntR;

  // Synchronize, count consecutive differing samples, flip and pulse on rise.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      syncA  <= 1'b0;
      syncB  <= 1'b0;
      stateR <= 1'b0;
      cntR   <= {CW{1'b0}};
      oRise  <= 1'b0;
    end else begin
      syncA <= iGo;
      syncB <= syncA;
      oRise <= 1'b0;
      if (syncB == stateR) begin
        cntR <= {CW{1'b0}};
      end else if (cntR == LAST) begin
        stateR <= ~stateR;
        cntR   <= {CW{1'b0}};
        oRise  <= ~stateR;
      end else begin
        cntR <= cntR + CW'(1);
      end
    end
  end

endmodule

// File: rtl/com_fifo.sv
// MCU command intake: debounced write strobe feeding a show-ahead FIFO whose
// head word is also decoded into one-hot command lines.
module com_fifo
  import com_pkg::*;
#(
  parameter int DEPTH           = 512,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [8:0]  iD,
  input  logic        iCmd,
  input  logic        iGo,
  input  logic        iPop,
  output logic [9:0]  oQ,
  output logic        oIsCmd,
  output logic [15:0] oDec,
  output logic        oEmpty,
  output logic        oFull,
  output logic [9:0]  oUsed,
  output logic        oFullPersistent
);

  localparam int AW = $clog2(DEPTH);

  logic          pushPulse;
  com_word_t     inWord;
  com_word_t     mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [9:0]    usedR;
  logic [9:0]    usedNext;
  logic          emptyR;
  logic          fullR;
  logic          persistR;
  logic          doPush;
  logic          doPop;
  logic          drop;

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDebounce (
    .iClk  (iClk),
    .iRst  (iRst),
    .iGo   (iGo),
    .oRise (pushPulse)
  );

  // Data is captured alongside the strobe synchronizer.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      inWord <= '0;
    end else begin
      inWord <= '{cmd: iCmd, data: iD};
    end
  end

  // Accept/drop decisions; a pop frees a slot for a same-cycle push when full.
  always_comb begin
    doPop    = iPop && !emptyR;
    doPush   = pushPulse && (!fullR || doPop);
    drop     = pushPulse && fullR && !doPop;
    usedNext = usedR;
    case ({doPush, doPop})
      2'b10:   usedNext = usedR + 10'd1;
      2'b01:   usedNext = usedR - 10'd1;
      default: usedNext = usedR;
    endcase
  end

  // Storage array, no reset needed since reads are gated by the empty flag.
  always_ff @(posedge iClk) begin
    if (doPush) begin
      mem[wrPtr] <= inWord;
    end
  end

  // Pointers, occupancy and status flags.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      wrPtr    <= {AW{1'b0}};
      rdPtr    <= {AW{1'b0}};
      usedR    <= 10'd0;
      emptyR   <= 1'b1;
      fullR    <= 1'b0;
      persistR <= 1'b0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + AW'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + AW'(1);
      end
      usedR    <= usedNext;
      emptyR   <= (usedNext == 10'd0);
      fullR    <= (usedNext == 10'(DEPTH));
      persistR <= persistR | fullR | drop;
    end
  end

  always_comb begin
    oQ              = emptyR ? 10'd0 : mem[rdPtr];
    oIsCmd          = oQ[9];
    oDec            = decodeOneHot(oQ[3:0], !emptyR);
    oEmpty          = emptyR;
    oFull           = fullR;
    oUsed           = usedR;
    oFullPersistent = persistR;
  end

endmodule

// File: tb/tb_com_fifo.sv
// Directed bench for com_fifo: vector table for push/pop sequences plus
// hand-written latency, glitch, full, same-cycle and reset scenarios.
module tb_com_fifo;

  localparam int DEPTH = 16;
  localparam int D     = 16;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic [8:0]  iD   = 9'd0;
  logic        iCmd = 1'b0;
  logic        iGo  = 1'b0;
  logic        iPop = 1'b0;
  logic [9:0]  oQ;
  logic        oIsCmd;
  logic [15:0] oDec;
  logic        oEmpty;
  logic        oFull;
  logic [9:0]  oUsed;
  logic        oFullPersistent;

  int nCmp = 0;
  int nBad = 0;

  com_fifo #(.DEPTH(DEPTH), .DEBOUNCE_CYCLES(D)) dut (
    .iClk(iClk), .iRst(iRst), .iD(iD), .iCmd(iCmd), .iGo(iGo), .iPop(iPop),
    .oQ(oQ), .oIsCmd(oIsCmd), .oDec(oDec), .oEmpty(oEmpty), .oFull(oFull),
    .oUsed(oUsed), .oFullPersistent(oFullPersistent)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    bit          isPush;
    logic        cmd;
    logic [8:0]  d;
    logic [9:0]  expQ;
    logic [9:0]  expUsed;
    logic        expEmpty;
    logic [15:0] expDec;
  } vec_t;

  vec_t vecs [9];

  task automatic tick(input int n);
    repeat (n) @(posedge iClk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkState(input string name, input logic [9:0] q, input logic [9:0] used,
                            input logic empty, input logic [15:0] dec);
    check({name, ".oQ"}, 32'(oQ), 32'(q));
    check({name, ".oUsed"}, 32'(oUsed), 32'(used));
    check({name, ".oEmpty"}, 32'(oEmpty), 32'(empty));
    check({name, ".oDec"}, 32'(oDec), 32'(dec));
    check({name, ".oIsCmd"}, 32'(oIsCmd), 32'(q[9]));
  endtask

  task automatic doReset();
    iRst = 1'b1;
    iGo  = 1'b0;
    iPop = 1'b0;
    tick(2);
    iRst = 1'b0;
  endtask

  task automatic pushWord(input logic c, input logic [8:0] d);
    iCmd = c;
    iD   = d;
    iGo  = 1'b1;
    tick(D + 4);
    iGo  = 1'b0;
    tick(D + 4);
  endtask

  task automatic popWord();
    iPop = 1'b1;
    tick(1);
    iPop = 1'b0;
  endtask

  // Push a word while popping exactly on the push edge (edge 3+D after rise).
  task automatic pushWithPop(input logic c, input logic [8:0] d);
    iCmd = c;
    iD   = d;
    iGo  = 1'b1;
    tick(2 + D);
    iPop = 1'b1;
    tick(1);
    iPop = 1'b0;
    tick(2);
    iGo  = 1'b0;
    tick(D + 4);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 9'h012, 10'h012, 10'd1, 1'b0, 16'h0004};
    vecs[1] = '{1'b1, 1'b0, 9'h034, 10'h012, 10'd2, 1'b0, 16'h0004};
    vecs[2] = '{1'b0, 1'b0, 9'h000, 10'h034, 10'd1, 1'b0, 16'h0010};
    vecs[3] = '{1'b0, 1'b0, 9'h000, 10'h000, 10'd0, 1'b1, 16'h0000};
    vecs[4] = '{1'b0, 1'b0, 9'h000, 10'h000, 10'd0, 1'b1, 16'h0000};
    vecs[5] = '{1'b1, 1'b1, 9'h005, 10'h205, 10'd1, 1'b0, 16'h0020};
    vecs[6] = '{1'b1, 1'b1, 9'h00F, 10'h205, 10'd2, 1'b0, 16'h0020};
    vecs[7] = '{1'b0, 1'b0, 9'h000, 10'h20F, 10'd1, 1'b0, 16'h8000};
    vecs[8] = '{1'b0, 1'b0, 9'h000, 10'h000, 10'd0, 1'b1, 16'h0000};

    // Reset state
    doReset();
    checkState("reset", 10'h000, 10'd0, 1'b1, 16'h0000);
    check("reset.oFull", 32'(oFull), 32'd0);
    check("reset.oFullPersistent", 32'(oFullPersistent), 32'd0);

    // Strobe latency: nothing after edge 2+D, word visible after edge 3+D
    iCmd = 1'b1;
    iD   = 9'h004;
    @(negedge iClk);
    iGo = 1'b1;
    repeat (2 + D) @(posedge iClk);
    #1;
    check("latency.notYet", 32'(oUsed), 32'd0);
    tick(1);
    checkState("latency", 10'h204, 10'd1, 1'b0, 16'h0010);
    iGo = 1'b0;
    tick(D + 4);

    // Short glitch never pushes
    doReset();
    iGo = 1'b1;
    tick(5);
    iGo = 1'b0;
    tick(3 * D);
    checkState("glitch", 10'h000, 10'd0, 1'b1, 16'h0000);

    // Table-driven push/pop sequences
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].isPush) begin
        pushWord(vecs[i].cmd, vecs[i].d);
      end else begin
        popWord();
        tick(1);
      end
      checkState($sformatf("vec%0d", i), vecs[i].expQ, vecs[i].expUsed,
                 vecs[i].expEmpty, vecs[i].expDec);
    end

    // Fill to DEPTH, one extra push is dropped
    doReset();
    for (int i = 0; i < DEPTH; i++) begin
      pushWord(1'b0, 9'(i + 1));
    end
    check("full.oFull", 32'(oFull), 32'd1);
    pushWord(1'b0, 9'h1FF);
    check("full.oUsed", 32'(oUsed), 32'(DEPTH));
    check("full.oFullPersistent", 32'(oFullPersistent), 32'd1);
    check("full.head", 32'(oQ), 32'h001);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("drain%0d", i), 32'(oQ), 32'(i + 1));
      popWord();
    end
    checkState("drained", 10'h000, 10'd0, 1'b1, 16'h0000);
    check("drained.oFull", 32'(oFull), 32'd0);
    check("drained.persist", 32'(oFullPersistent), 32'd1);
    doReset();
    check("persist.cleared", 32'(oFullPersistent), 32'd0);

    // Same-cycle push and pop at used=3
    pushWord(1'b0, 9'h0A1);
    pushWord(1'b0, 9'h0A2);
    pushWord(1'b0, 9'h0A3);
    pushWithPop(1'b0, 9'h0A4);
    checkState("pushpop3", 10'h0A2, 10'd3, 1'b0, 16'h0004);

    // Same-cycle push and pop while empty: pop ignored
    doReset();
    pushWithPop(1'b1, 9'h003);
    checkState("pushpopEmpty", 10'h203, 10'd1, 1'b0, 16'h0008);

    // Reset mid-stream with five words queued
    doReset();
    for (int i = 0; i < 5; i++) begin
      pushWord(1'b1, 9'(16 + i));
    end
    check("mid.used5", 32'(oUsed), 32'd5);
    iRst = 1'b1;
    tick(1);
    checkState("midReset", 10'h000, 10'd0, 1'b1, 16'h0000);
    check("midReset.oFull", 32'(oFull), 32'd0);
    check("midReset.persist", 32'(oFullPersistent), 32'd0);
    iRst = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
